mux4_rr_arb: RTL

Round-robin arbiter and select sequencer for the shared 4-to-1 single-bit multiplexer datapath. Four requesters each drive one data bit and a request line. The block grants the mux to one requester at a time, drives the 2-bit select, and presents the selected bit with a valid flag. It sits between the requester logic and the downstream consumer of the muxed bit.

---
 rtl/mux4_rr_arb_pkg.sv | 22 ++
 rtl/mux4_rr_arb_if.sv | 31 +++
 rtl/mux4_rr_arb_rr_pick4.sv | 37 +++
 rtl/mux4_rr_arb.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mux4_rr_arb_pkg.sv
// mux4_rr_arb shared package: sizes, FSM state type, helpers.
// Optional hold limit is enabled by the MUX4_ARB_HOLD_LIMIT_EN macro.
package mux4_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

   function automatic logic [NREQ-1:0] onehot4(
      input logic [SEL_W-1:0] idx
   );
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux4_rr_arb_if.sv
// Requester/consumer bundle for the shared 4:1 mux arbiter.
// master = requester/consumer side, slave = arbiter side.
interface mux4_rr_arb_if;
   import mux4_arb_pkg::*;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  ip;
   logic [NREQ-1:0]  gnt;
   logic [SEL_W-1:0] sIp;
   logic             op;
   logic             vld;

   modport master (
      output req,
      output ip,
      input  gnt,
      input  sIp,
      input  op,
      input  vld
   );

   modport slave (
      input  req,
      input  ip,
      output gnt,
      output sIp,
      output op,
      output vld
   );

endinterface

// File: rtl/mux4_rr_arb_rr_pick4.sv
// Combinational round-robin picker: first set req bit from ptr upward.
// The excluded index masks a releasing owner out of the search.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic             excl_en_i,
   input  logic [SEL_W-1:0] excl_idx_i,
   output logic             any_o,
   output logic [SEL_W-1:0] win_o
);

   logic [NREQ-1:0]  masked;
   logic [SEL_W-1:0] idx;
   logic             found;

   // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); the 2-bit add wraps for free
   always_comb begin
      masked = req_i;
      if (excl_en_i) begin
         masked[excl_idx_i] = 1'b0;
      end
      any_o = |masked;
      win_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_i + SEL_W'(k);
         if (!found && masked[idx]) begin
            win_o = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter and select sequencer for a shared 4:1 bit mux.
// Define MUX4_ARB_HOLD_LIMIT_EN to cap ownership at HOLD_MAX cycles.
module mux4_rr_arb
   import mux4_arb_pkg::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   mux4_rr_arb_if.slave bus
);

   if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold
      $error("HOLD_MAX must be in 1..15");
   end

   arb_state_t       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             vld_q, vld_d;

   logic             pick_any;
   logic [SEL_W-1:0] pick_win;
   logic             pick_excl;
   logic             hold_hit;
   logic             rearb;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

   logic [3:0] hold_q, hold_d;

   assign hold_hit = (hold_q == HOLD_LIM);
`else
   assign hold_hit = 1'b0;
`endif

   // A releasing owner is masked so it cannot win its own handover
   assign pick_excl = (state_q == GRANT) && !bus.req[sel_q];

   rr_pick4 u_pick (
      .req_i      (bus.req),
      .ptr_i      (ptr_q),
      .excl_en_i  (pick_excl),
      .excl_idx_i (sel_q),
      .any_o      (pick_any),
      .win_o      (pick_win)
   );

   // Next-state: decide whether to (re)arbitrate, then load the winner
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      vld_d   = vld_q;
      rearb   = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      hold_d  = hold_q;
`endif
      unique case (state_q)
         IDLE: begin
            rearb = 1'b1;
         end
         GRANT: begin
            if (!bus.req[sel_q] || hold_hit) begin
               rearb = 1'b1;
            end else begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
               if (hold_q != HOLD_LIM) begin
                  hold_d = hold_q + 4'd1;
               end
`endif
            end
         end
         default: begin
            rearb = 1'b1;
         end
      endcase

      if (rearb) begin
         if (pick_any) begin
            state_d = GRANT;
            gnt_d   = onehot4(pick_win);
            sel_d   = pick_win;
            vld_d   = 1'b1;
            ptr_d   = pick_win + 2'd1;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            hold_d  = '0;
`endif
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            vld_d   = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            hold_d  = '0;
`endif
         end
      end
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         vld_q   <= vld_d;
      end
   end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   // Hold counter for the current ownership period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign bus.gnt = gnt_q;
   assign bus.sIp = sel_q;
   assign bus.vld = vld_q;
   assign bus.op  = bus.ip[sel_q] & vld_q;

endmodule
